mod_multiplicador_sec: RTL and testbench

MOD_MULTIPLICADOR_SEC -- requirements
Module: mod_multiplicador_sec

---
 rtl/mod_multiplicador_sec.sv | 110 +++++++++++
 tb/tb_mod_multiplicador_sec.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mod_multiplicador_sec.sv
// mod_multiplicador_sec: sequential shift-add signed multiplier (sign-magnitude, one partial product per cycle).
// Define MOD_MULTIPLICADOR_SAT_EN to saturate Y on overflow instead of wrapping.
module mod_multiplicador_sec #(
    parameter int WIDTH    = 6,
    parameter int FACTOR_W = 4,
    parameter int OUT_W    = 9
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [WIDTH-1:0]    A,
    input  logic [FACTOR_W-1:0] B,
    output logic [OUT_W-1:0]    Y,
    output logic                OF,
    output logic                BUSY,
    output logic                DONE
);
    localparam int P  = WIDTH + FACTOR_W;
    localparam int CW = $clog2(FACTOR_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [P-1:0]          a_q, a_d;
    logic [FACTOR_W-1:0]   b_q, b_d;
    logic                  sign_q, sign_d;
    logic [P-1:0]          acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [OUT_W-1:0]      y_q, y_d;
    logic                  of_q, of_d;
    logic [P-1:0]          full;
    logic                  of_w;
    logic [WIDTH-1:0]      a_mag;
    logic [FACTOR_W-1:0]   b_mag;

    // Magnitudes of the most-negative operands still fit the unsigned captures.
    assign a_mag = A[WIDTH-1] ? -A : A;
    assign b_mag = B[FACTOR_W-1] ? -B : B;
    assign full  = sign_q ? (P'(0) - acc_q) : acc_q;
    assign of_w  = full[P-1:OUT_W-1] != {(P-OUT_W+1){full[P-1]}};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        of_d    = of_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = START ? S_CALC : S_IDLE;
                if (START) begin
                    a_d    = P'(a_mag);
                    b_d    = b_mag;
                    sign_d = A[WIDTH-1] ^ B[FACTOR_W-1];
                    acc_d  = '0;
                    cnt_d  = '0;
                end
            end
            S_CALC: begin
                // The multiplicand shifts left and the multiplier right, so bit 0 always selects.
                acc_d   = acc_q + (b_q[0] ? a_q : '0);
                a_d     = a_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(FACTOR_W - 1)) ? S_FIX : S_CALC;
            end
            S_FIX: begin
                of_d    = of_w;
`ifdef MOD_MULTIPLICADOR_SAT_EN
                y_d     = of_w ? (full[P-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}})
                               : full[OUT_W-1:0];
`else
                y_d     = full[OUT_W-1:0];
`endif
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            of_q    <= of_d;
        end
    end

    assign Y    = y_q;
    assign OF   = of_q;
    assign BUSY = (state_q == S_CALC) || (state_q == S_FIX);
    assign DONE = state_q == S_DONE;
endmodule

// File: tb/tb_mod_multiplicador_sec.sv
// tb_mod_multiplicador_sec: random and directed checks of the sequential multiplier against integer arithmetic.
module tb_mod_multiplicador_sec;
    localparam int WIDTH    = 6;
    localparam int FACTOR_W = 4;
    localparam int OUT_W    = 9;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic                START = 1'b0;
    logic [WIDTH-1:0]    A = '0;
    logic [FACTOR_W-1:0] B = '0;
    logic [OUT_W-1:0]    Y;
    logic                OF;
    logic                BUSY;
    logic                DONE;

    int n_cmp = 0;
    int n_err = 0;

    mod_multiplicador_sec #(.WIDTH(WIDTH), .FACTOR_W(FACTOR_W), .OUT_W(OUT_W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
        .Y(Y), .OF(OF), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_of(input int a, input int b);
        int p = a * b;
        int lim = 1 << (OUT_W - 1);
        return (p < -lim || p > lim - 1) ? 1 : 0;
    endfunction

    function automatic int model_y(input int a, input int b);
        int p = a * b;
        int lim = 1 << (OUT_W - 1);
        int mask = (1 << OUT_W) - 1;
`ifdef MOD_MULTIPLICADOR_SAT_EN
        if (p > lim - 1) p = lim - 1;
        if (p < -lim) p = -lim;
`endif
        return p & mask;
    endfunction

    // mode 0: plain, 1: re-assert START mid-CALC with A=1,B=1
    task automatic do_mul(input int av, input int bv, input int mode);
        int n = 0;
        int busy = 0;
        @(negedge CLK);
        START = 1'b1;
        A = av[WIDTH-1:0];
        B = bv[FACTOR_W-1:0];
        @(negedge CLK);
        START = 1'b0;
        while (!DONE && n < 20) begin
            busy += int'(BUSY);
            if (mode == 1 && n == 2) begin
                START = 1'b1;
                A = 6'd1;
                B = 4'd1;
            end
            @(negedge CLK);
            START = 1'b0;
            n++;
        end
        check($sformatf("latency %0d*%0d", av, bv), n, FACTOR_W + 1);
        check($sformatf("busy %0d*%0d", av, bv), busy, FACTOR_W + 1);
        check($sformatf("y %0d*%0d", av, bv), {23'b0, Y}, model_y(av, bv));
        check($sformatf("of %0d*%0d", av, bv), {31'b0, OF}, model_of(av, bv));
        @(negedge CLK);
        check("done_single", {31'b0, DONE}, 0);
        check("y_held", {23'b0, Y}, model_y(av, bv));
    endtask

    initial begin
        int dirs[8][2] = '{'{7, 5}, '{-13, 5}, '{0, -8}, '{-32, -8}, '{3, -3}, '{-32, 7}, '{31, -8}, '{31, 7}};
        int hits[$];
        int n;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_y", {23'b0, Y}, 0);
        check("rst_of", {31'b0, OF}, 0);
        check("rst_busy", {31'b0, BUSY}, 0);
        check("rst_done", {31'b0, DONE}, 0);

        foreach (dirs[i]) do_mul(dirs[i][0], dirs[i][1], 0);
        do_mul(7, 5, 1);

        // Reset during the third CALC cycle aborts with no DONE pulse
        @(negedge CLK);
        START = 1'b1; A = 6'd7; B = 4'd5;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_busy", {31'b0, BUSY}, 0);
        check("abort_done", {31'b0, DONE}, 0);
        check("abort_y", {23'b0, Y}, 0);
        check("abort_of", {31'b0, OF}, 0);
        n = 0;
        repeat (8) begin
            @(negedge CLK);
            n += int'(DONE);
        end
        check("abort_no_done", n, 0);
        do_mul(3, -3, 0);

        // START coinciding with RST is discarded
        @(negedge CLK);
        START = 1'b1; RST = 1'b1; A = 6'd2; B = 4'd2;
        @(negedge CLK);
        START = 1'b0; RST = 1'b0;
        check("rst_start_busy", {31'b0, BUSY}, 0);

        // Continuous START gives one result every FACTOR_W+2 cycles
        @(negedge CLK);
        START = 1'b1; A = 6'd2; B = 4'd3;
        n = 0;
        while (hits.size() < 3 && n < 100) begin
            @(negedge CLK);
            n++;
            if (DONE) begin
                hits.push_back(n);
                check("b2b_y", {23'b0, Y}, 6);
            end
        end
        check("b2b_count", hits.size(), 3);
        if (hits.size() == 3) begin
            check("b2b_period1", hits[1] - hits[0], FACTOR_W + 2);
            check("b2b_period2", hits[2] - hits[1], FACTOR_W + 2);
        end
        START = 1'b0;
        repeat (8) @(negedge CLK);

        repeat (60) begin
            int av = int'($urandom_range(0, 63)) - 32;
            int bv = int'($urandom_range(0, 15)) - 8;
            do_mul(av, bv, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
